// File: rtl/plugin_mmio_hub.sv
// plugin_mmio_hub: NUM_CH independent plugin compute channels in the plugin window.
// Each channel has OP_A, OP_B, CTRL and RESULT registers and an IDLE/BUSY/DONE
// sequencer with a LATENCY-cycle compute delay. Read data is registered.
// Optional feature macro: PLUGIN_IRQ_EN (IE storage plus registered completion irq_o).
module plugin_mmio_hub #(
  parameter int NUM_CH  = 4,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable_i,
  input  logic [3:0]  we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        irq_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [7:0] LAT_LOAD = 8'(LATENCY - 1);
  localparam logic [7:0] NUM_CH_L = 8'(NUM_CH);

  // Merge write data into a register honouring the byte enables.
  function automatic logic [31:0] be_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[b*8 +: 8] = be[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return r;
  endfunction

  // Operation unit; all results are modulo 2^32.
  function automatic logic [31:0] compute(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a << b[4:0];
      3'd6:    return a >> b[4:0];
      3'd7:    return a * b;
      default: return 32'd0;
    endcase
  endfunction

  logic [31:0] op_a_q [NUM_CH], op_a_d [NUM_CH];
  logic [31:0] op_b_q [NUM_CH], op_b_d [NUM_CH];
  logic [31:0] snap_a_q [NUM_CH], snap_a_d [NUM_CH];
  logic [31:0] snap_b_q [NUM_CH], snap_b_d [NUM_CH];
  logic [31:0] result_q [NUM_CH], result_d [NUM_CH];
  logic [2:0]  snap_op_q [NUM_CH], snap_op_d [NUM_CH];
  logic [2:0]  op_q [NUM_CH], op_d [NUM_CH];
  logic [1:0]  state_q [NUM_CH], state_d [NUM_CH];
  logic [7:0]  cnt_q [NUM_CH], cnt_d [NUM_CH];
  logic        err_q [NUM_CH], err_d [NUM_CH];
`ifdef PLUGIN_IRQ_EN
  logic        ie_q [NUM_CH], ie_d [NUM_CH];
`endif
  logic [31:0] data_q, rd_data_s;
  logic        wr_s, rd_s, ch_ok_s, ie_rd_s;
  logic        unused_addr_s;

  assign unused_addr_s = ^{addr_i[31:12], addr_i[1:0]};
  assign data_o = data_q;

  // Next-state logic for every channel: sequencer, bus writes and read mux.
  always_comb begin
    wr_s      = enable_i && (we_i != 4'b0000);
    rd_s      = enable_i && (we_i == 4'b0000);
    ch_ok_s   = (addr_i[11:4] < NUM_CH_L);
    rd_data_s = 32'd0;
    ie_rd_s   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      op_a_d[i]    = op_a_q[i];
      op_b_d[i]    = op_b_q[i];
      snap_a_d[i]  = snap_a_q[i];
      snap_b_d[i]  = snap_b_q[i];
      snap_op_d[i] = snap_op_q[i];
      result_d[i]  = result_q[i];
      op_d[i]      = op_q[i];
      state_d[i]   = state_q[i];
      cnt_d[i]     = cnt_q[i];
      err_d[i]     = err_q[i];
`ifdef PLUGIN_IRQ_EN
      ie_d[i]      = ie_q[i];
`endif
      // Countdown; result lands together with the BUSY->DONE transition.
      case (state_q[i])
        ST_BUSY: begin
          if (cnt_q[i] == 8'd0) begin
            result_d[i] = compute(snap_op_q[i], snap_a_q[i], snap_b_q[i]);
            state_d[i]  = ST_DONE;
          end else begin
            cnt_d[i] = cnt_q[i] - 8'd1;
          end
        end
        default: ;
      endcase
      if (wr_s && ch_ok_s && (addr_i[11:4] == 8'(i))) begin
        case (addr_i[3:2])
          2'd0: op_a_d[i] = be_merge(op_a_q[i], data_i, we_i);
          2'd1: op_b_d[i] = be_merge(op_b_q[i], data_i, we_i);
          2'd2: begin
            if (we_i[0]) begin
              op_d[i] = data_i[3:1];
`ifdef PLUGIN_IRQ_EN
              ie_d[i] = data_i[4];
`endif
              // Clear first so a colliding START in the same write still flags.
              if (data_i[5]) begin
                err_d[i] = 1'b0;
              end else begin
                err_d[i] = err_q[i];
              end
              if (data_i[0]) begin
                if (state_q[i] == ST_BUSY) begin
                  err_d[i] = 1'b1;
                end else begin
                  snap_a_d[i]  = op_a_q[i];
                  snap_b_d[i]  = op_b_q[i];
                  snap_op_d[i] = data_i[3:1];
                  cnt_d[i]     = LAT_LOAD;
                  state_d[i]   = ST_BUSY;
                end
              end else begin
                state_d[i] = state_d[i];
              end
            end else begin
              op_d[i] = op_q[i];
            end
          end
          default: ;
        endcase
      end else begin
        op_a_d[i] = op_a_d[i];
      end
      if (rd_s && ch_ok_s && (addr_i[11:4] == 8'(i))) begin
`ifdef PLUGIN_IRQ_EN
        ie_rd_s = ie_q[i];
`endif
        case (addr_i[3:2])
          2'd0: rd_data_s = op_a_q[i];
          2'd1: rd_data_s = op_b_q[i];
          2'd2: rd_data_s = {25'd0, ie_rd_s, op_q[i], err_q[i],
                             state_q[i] == ST_DONE, state_q[i] == ST_BUSY};
          default: begin
            rd_data_s = result_q[i];
            // Reading the result acknowledges completion.
            if (state_q[i] == ST_DONE) begin
              state_d[i] = ST_IDLE;
            end else begin
              state_d[i] = state_d[i];
            end
          end
        endcase
      end else begin
        rd_data_s = rd_data_s;
      end
    end
  end

  // State registers; read data only updates on a read cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        op_a_q[i]    <= 32'd0;
        op_b_q[i]    <= 32'd0;
        snap_a_q[i]  <= 32'd0;
        snap_b_q[i]  <= 32'd0;
        snap_op_q[i] <= 3'd0;
        result_q[i]  <= 32'd0;
        op_q[i]      <= 3'd0;
        state_q[i]   <= ST_IDLE;
        cnt_q[i]     <= 8'd0;
        err_q[i]     <= 1'b0;
`ifdef PLUGIN_IRQ_EN
        ie_q[i]      <= 1'b0;
`endif
      end
      data_q <= 32'd0;
    end else begin
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      snap_a_q  <= snap_a_d;
      snap_b_q  <= snap_b_d;
      snap_op_q <= snap_op_d;
      result_q  <= result_d;
      op_q      <= op_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`ifdef PLUGIN_IRQ_EN
      ie_q      <= ie_d;
`endif
      if (rd_s) begin
        data_q <= rd_data_s;
      end
    end
  end

`ifdef PLUGIN_IRQ_EN
  logic irq_d, irq_q;

  // Level interrupt request: any channel DONE with IE set.
  always_comb begin
    irq_d = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if ((state_q[i] == ST_DONE) && ie_q[i]) begin
        irq_d = 1'b1;
      end else begin
        irq_d = irq_d;
      end
    end
  end

  // Registered interrupt output.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_plugin_mmio_hub.sv
// Self-checking bench for plugin_mmio_hub (NUM_CH=4, LATENCY=3).
// Reads push their expected value into a scoreboard; each scenario drains it.
module tb_plugin_mmio_hub;
  localparam int LAT = 3;
`ifdef PLUGIN_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable_i = 1'b0;
  logic [3:0]  we_i = 4'b0000;
  logic [31:0] addr_i = 32'd0;
  logic [31:0] data_i = 32'd0;
  logic [31:0] data_o;
  logic        irq_o;

  int nvec = 0;
  int nmis = 0;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  string       tag_q[$];

  plugin_mmio_hub #(.NUM_CH(4), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .enable_i(enable_i), .we_i(we_i),
    .addr_i(addr_i), .data_i(data_i), .data_o(data_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_addr(input int ch, input int r);
    return 32'h1000_0000 | (32'(ch) << 4) | (32'(r) << 2);
  endfunction

  // All bus tasks start and end at a falling edge and take one cycle.
  task automatic wr(input int ch, input int r, input logic [31:0] d, input logic [3:0] be);
    enable_i = 1'b1; we_i = be; addr_i = mk_addr(ch, r); data_i = d;
    @(negedge clk);
    enable_i = 1'b0; we_i = 4'b0000;
  endtask

  task automatic rd(input int ch, input int r, input logic [31:0] e, input string tag);
    enable_i = 1'b1; we_i = 4'b0000; addr_i = mk_addr(ch, r);
    exp_q.push_back(e); tag_q.push_back(tag);
    @(negedge clk);
    enable_i = 1'b0;
    obs_q.push_back(data_o);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [31:0] e, o;
    string t;
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    nvec++;
    if (data_o !== 32'd0) begin nmis++; $display("FAIL reset_data_o: got %h expected %h", data_o, 32'd0); end
    nvec++;
    if (irq_o !== 1'b0) begin nmis++; $display("FAIL reset_irq: got %b expected 0", irq_o); end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        rd(c, r, 32'd0, $sformatf("reset_ch%0d_reg%0d", c, r));
    wr(2, 0, 32'h1234_5678, 4'b0011);
    rd(2, 0, 32'h0000_5678, "ch2_opa_byte_enable");
    wr(1, 0, 32'hDEAD_BEEF, 4'b1111);
    nvec++;
    if (data_o !== 32'h0000_5678) begin nmis++; $display("FAIL write_keeps_data_o: got %h expected %h", data_o, 32'h0000_5678); end
    wr(5, 0, 32'hFFFF_FFFF, 4'b1111);
    rd(5, 0, 32'd0, "ch5_out_of_range");
    rd(1, 0, 32'hDEAD_BEEF, "ch1_opa_full_write");
    wr(1, 0, 32'd0, 4'b1111);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      nvec++;
      if (o !== e) begin nmis++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask

  task automatic test_add;
    logic [31:0] e, o;
    string t;
    wr(0, 0, 32'd7, 4'b1111);
    wr(0, 1, 32'd5, 4'b1111);
    wr(0, 2, 32'h01, 4'b0001);                // accepted at edge E
    rd(0, 2, 32'h01, "add_busy_e1");          // captured E+1
    rd(0, 2, 32'h01, "add_busy_e2");          // captured E+2
    rd(0, 2, 32'h01, "add_busy_before_done"); // captured E+3, pre-update
    rd(0, 2, 32'h02, "add_done");             // captured E+4
    rd(0, 3, 32'd12, "add_result");
    rd(0, 2, 32'h00, "add_ctrl_after_result");
    rd(0, 3, 32'd12, "add_result_idle_reread");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      nvec++;
      if (o !== e) begin nmis++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask

  task automatic test_op_sweep;
    logic [31:0] e, o;
    string t;
    logic [31:0] exp_tab [8];
    exp_tab[0] = 32'h0000_0001; exp_tab[1] = 32'hFFFF_FFFD;
    exp_tab[2] = 32'h0000_0002; exp_tab[3] = 32'hFFFF_FFFF;
    exp_tab[4] = 32'hFFFF_FFFD; exp_tab[5] = 32'hFFFF_FFFC;
    exp_tab[6] = 32'h3FFF_FFFF; exp_tab[7] = 32'hFFFF_FFFE;
    wr(1, 0, 32'hFFFF_FFFF, 4'b1111);
    wr(1, 1, 32'd2, 4'b1111);
    for (int op = 0; op < 8; op++) begin
      wr(1, 2, (32'(op) << 1) | 32'h1, 4'b0001);
      idle(LAT);
      rd(1, 3, exp_tab[op], $sformatf("sweep_op%0d_result", op));
      rd(1, 2, 32'(op) << 3, $sformatf("sweep_op%0d_ctrl", op));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      nvec++;
      if (o !== e) begin nmis++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask

  task automatic test_busy_collision;
    logic [31:0] e, o;
    string t;
    wr(3, 0, 32'd1, 4'b1111);
    wr(3, 1, 32'd1, 4'b1111);
    wr(3, 2, 32'h01, 4'b0001);     // E
    wr(3, 0, 32'd100, 4'b1111);    // E+1, operand change while busy
    wr(3, 2, 32'h01, 4'b0001);     // E+2, START while busy
    idle(1);
    rd(3, 3, 32'd2, "collision_result_snapshot");
    rd(3, 2, 32'h04, "collision_err_sticky");
    wr(3, 2, 32'h00, 4'b0001);
    rd(3, 2, 32'h04, "err_survives_plain_ctrl");
    wr(3, 2, 32'h20, 4'b0001);
    rd(3, 2, 32'h00, "err_cleared");
    wr(3, 2, 32'h01, 4'b0001);
    idle(LAT);
    rd(3, 3, 32'd101, "restart_result");
    rd(3, 2, 32'h00, "restart_ctrl_idle");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      nvec++;
      if (o !== e) begin nmis++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask

  task automatic test_parallel_and_reset;
    logic [31:0] e, o;
    string t;
    wr(0, 2, 32'h01, 4'b0001);     // ch0 start at E0 (7+5)
    wr(1, 2, 32'h01, 4'b0001);     // ch1 start at E0+1 (FFFFFFFF+2)
    idle(1);
    rd(0, 2, 32'h01, "par_ch0_busy_e3");
    rd(1, 2, 32'h01, "par_ch1_busy_e4");
    rd(0, 2, 32'h02, "par_ch0_done");
    rd(1, 2, 32'h02, "par_ch1_done");
    rd(0, 3, 32'd12, "par_ch0_result");
    rd(1, 3, 32'd1, "par_ch1_result");
    wr(2, 1, 32'd9, 4'b1111);
    wr(2, 2, 32'h01, 4'b0001);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    nvec++;
    if (data_o !== 32'd0) begin nmis++; $display("FAIL midop_reset_data_o: got %h expected %h", data_o, 32'd0); end
    idle(LAT + 2);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        rd(c, r, 32'd0, $sformatf("midop_reset_ch%0d_reg%0d", c, r));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      nvec++;
      if (o !== e) begin nmis++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask

  task automatic test_irq;
    logic [31:0] e, o;
    string t;
    wr(0, 0, 32'd1, 4'b1111);
    wr(0, 1, 32'd2, 4'b1111);
    wr(0, 2, 32'h11, 4'b0001);     // E, IE=1
    for (int k = 1; k <= LAT + 1; k++) begin
      idle(1);
      nvec++;
      if (irq_o !== (IRQ_EN && (k == LAT + 1)))
        begin nmis++; $display("FAIL irq_rise_k%0d: got %b expected %b", k, irq_o, IRQ_EN && (k == LAT + 1)); end
    end
    rd(0, 3, 32'd3, "irq_result");
    nvec++;
    if (irq_o !== IRQ_EN) begin nmis++; $display("FAIL irq_hold_after_read: got %b expected %b", irq_o, IRQ_EN); end
    idle(1);
    nvec++;
    if (irq_o !== 1'b0) begin nmis++; $display("FAIL irq_drop: got %b expected 0", irq_o); end
    rd(0, 2, IRQ_EN ? 32'h40 : 32'h00, "irq_ctrl_ie_readback");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      nvec++;
      if (o !== e) begin nmis++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_add;
    test_op_sweep;
    test_busy_collision;
    test_parallel_and_reset;
    test_irq;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
